// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Multi-domain reset sequencer. Synchronizes a reset button and
//               a PLL lock, debounces the button, holds every domain in reset
//               while any trigger is active, then releases the domains one by
//               one in ascending order with a fixed stagger.
//               Optional macro RESET_SEQ_CAUSE_EN compiles in the cause_out
//               register (last reset cause); otherwise cause_out is 2'b00.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_CHANNELS    = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int STAGGER_CYCLES  = 4
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    btn_in,
    input  logic                    locked_in,
    input  logic                    sw_req_in,
    output logic [NUM_CHANNELS-1:0] reset_out,
    output logic                    ready_out,
    output logic [1:0]              cause_out
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_STAG_W = $clog2(STAGGER_CYCLES + 1);

    localparam logic [c_DB_W-1:0]       c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0]     c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_STAG_W-1:0]     c_STAG_LAST = c_STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [NUM_CHANNELS-1:0] c_CH0       = NUM_CHANNELS'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and button debounce
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_btn_sync;
    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_btn_s;
    logic                   w_lock_s;
    logic                   r_btn_db;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic                   w_trigger;

    // Bring the asynchronous button and lock into the clk_in domain.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_btn_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btn_in};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign w_btn_s  = r_btn_sync[SYNC_STAGES-1];
    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

    // Accept a new button level only after it has been stable for the whole window.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= '0;
        end else if (w_btn_s != r_btn_db) begin
            if (r_db_cnt == c_DB_LAST) begin
                r_btn_db <= w_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_trigger = r_btn_db | ~w_lock_s | sw_req_in;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_HOLD_W-1:0]     r_hold_cnt;
    logic [c_HOLD_W-1:0]     w_hold_nxt;
    logic [c_STAG_W-1:0]     r_stag_cnt;
    logic [c_STAG_W-1:0]     w_stag_nxt;
    logic [NUM_CHANNELS-1:0] r_reset;
    logic [NUM_CHANNELS-1:0] w_reset_nxt;
    logic [NUM_CHANNELS-1:0] w_reset_shift;
    logic                    r_ready;
    logic                    w_ready_nxt;

    // Clearing the lowest still-asserted channel is a left shift because
    // channels always release from bit 0 upward.
    assign w_reset_shift = r_reset << 1;

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_stag_cnt <= '0;
            r_reset    <= '1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_stag_cnt <= w_stag_nxt;
            r_reset    <= w_reset_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    // Next state, counter updates and next output values.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_stag_nxt  = r_stag_cnt;
        w_reset_nxt = r_reset;
        w_ready_nxt = r_ready;

        case (r_state)
            ST_HOLD: begin
                w_reset_nxt = '1;
                w_ready_nxt = 1'b0;
                w_stag_nxt  = '0;
                if (w_trigger) begin
                    w_hold_nxt = '0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    // Channel 0 leaves reset on the same edge the hold window ends.
                    w_hold_nxt  = '0;
                    w_reset_nxt = ~c_CH0;
                    if (NUM_CHANNELS == 1) begin
                        w_state_nxt = ST_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (w_trigger) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = '0;
                    w_stag_nxt  = '0;
                    w_reset_nxt = '1;
                    w_ready_nxt = 1'b0;
                end else if (r_stag_cnt == c_STAG_LAST) begin
                    w_stag_nxt  = '0;
                    w_reset_nxt = w_reset_shift;
                    if (w_reset_shift == '0) begin
                        w_state_nxt = ST_RUN;
                        w_ready_nxt = 1'b1;
                    end
                end else begin
                    w_stag_nxt = r_stag_cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (w_trigger) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = '0;
                    w_stag_nxt  = '0;
                    w_reset_nxt = '1;
                    w_ready_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_HOLD;
                w_hold_nxt  = '0;
                w_stag_nxt  = '0;
                w_reset_nxt = '1;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    assign reset_out = r_reset;
    assign ready_out = r_ready;

    // ------------------------------------------------------------------
    // Reset cause tracking
    // ------------------------------------------------------------------
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] r_cause;
    logic       w_enter_hold;

    assign w_enter_hold = (r_state != ST_HOLD) && w_trigger;

    // Record why normal operation was left; lock loss outranks the button,
    // the button outranks a software request.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_cause <= 2'b00;
        end else if (w_enter_hold) begin
            if (!w_lock_s) begin
                r_cause <= 2'b10;
            end else if (r_btn_db) begin
                r_cause <= 2'b01;
            end else begin
                r_cause <= 2'b11;
            end
        end
    end

    assign cause_out = r_cause;
`else
    assign cause_out = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (default parameters).
//               A cycle model derived from the trigger/hold/stagger rules is
//               compared against the DUT every cycle; directed scenarios add
//               literal expectations at hand-computed edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int N     = 2;
    localparam int SYNC  = 2;
    localparam int DEB   = 16;
    localparam int HOLD  = 8;
    localparam int STAG  = 4;
    localparam int LIMIT = HOLD + (N - 1) * STAG;

`ifdef RESET_SEQ_CAUSE_EN
    localparam logic [1:0] c_CAUSE_BTN  = 2'b01;
    localparam logic [1:0] c_CAUSE_LOCK = 2'b10;
    localparam logic [1:0] c_CAUSE_SW   = 2'b11;
`else
    localparam logic [1:0] c_CAUSE_BTN  = 2'b00;
    localparam logic [1:0] c_CAUSE_LOCK = 2'b00;
    localparam logic [1:0] c_CAUSE_SW   = 2'b00;
`endif

    logic         clk_in;
    logic         reset_in;
    logic         btn_in;
    logic         locked_in;
    logic         sw_req_in;
    logic [N-1:0] reset_out;
    logic         ready_out;
    logic [1:0]   cause_out;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer #(
        .NUM_CHANNELS    (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STAGGER_CYCLES  (STAG)
    ) dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .btn_in    (btn_in),
        .locked_in (locked_in),
        .sw_req_in (sw_req_in),
        .reset_out (reset_out),
        .ready_out (ready_out),
        .cause_out (cause_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: everything reduces to "edges since the last trigger".
    // Channel k is released once that count reaches HOLD + k*STAG.
    // ------------------------------------------------------------------
    bit         m_btn_q[$];
    bit         m_lock_q[$];
    bit         m_db;
    int         m_run;
    int         m_quiet;
    logic [1:0] m_cause;

    always @(posedge clk_in or posedge reset_in) begin : p_model
        bit sb;
        bit sl;
        bit trig;
        if (reset_in) begin
            m_btn_q.delete();
            m_lock_q.delete();
            m_db    = 1'b0;
            m_run   = 0;
            m_quiet = 0;
            m_cause = 2'b00;
        end else begin
            // Synchronized value seen at this edge = input sampled SYNC edges ago.
            sb   = (m_btn_q.size()  >= SYNC) ? m_btn_q[SYNC-1]  : 1'b0;
            sl   = (m_lock_q.size() >= SYNC) ? m_lock_q[SYNC-1] : 1'b0;
            trig = m_db || !sl || sw_req_in;
            if (trig) begin
                if (m_quiet >= HOLD) begin
                    if (!sl)       m_cause = 2'b10;
                    else if (m_db) m_cause = 2'b01;
                    else           m_cause = 2'b11;
                end
                m_quiet = 0;
            end else if (m_quiet < LIMIT) begin
                m_quiet++;
            end
            if (sb != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db  = sb;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_btn_q.push_front(btn_in);
            m_lock_q.push_front(locked_in);
            if (m_btn_q.size() > SYNC)  void'(m_btn_q.pop_back());
            if (m_lock_q.size() > SYNC) void'(m_lock_q.pop_back());
        end
    end

    function automatic logic [N-1:0] exp_reset(input int q);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (q < HOLD + k * STAG);
        return r;
    endfunction

    function automatic logic [1:0] exp_cause();
`ifdef RESET_SEQ_CAUSE_EN
        return m_cause;
`else
        return 2'b00;
`endif
    endfunction

    // Compare DUT against the model every cycle, away from the clock edge.
    always @(posedge clk_in) begin
        #2;
        check("model_reset_out", 32'(reset_out), 32'(exp_reset(m_quiet)));
        check("model_ready_out", 32'(ready_out), 32'(m_quiet >= LIMIT));
        check("model_cause_out", 32'(cause_out), 32'(exp_cause()));
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios with literal expectations
    // ------------------------------------------------------------------
    initial begin
        reset_in  = 1'b1;
        btn_in    = 1'b0;
        locked_in = 1'b0;
        sw_req_in = 1'b0;
        wait_edges(3);
        check("rst_reset_out", 32'(reset_out), 32'h3);
        check("rst_ready_out", 32'(ready_out), 32'h0);
        check("rst_cause_out", 32'(cause_out), 32'h0);

        // Power-up release: ch0 at edge 10, ch1 and ready at edge 14.
        @(negedge clk_in);
        locked_in = 1'b1;
        reset_in  = 1'b0;
        wait_edges(9);
        check("pwr_e9_reset",  32'(reset_out), 32'h3);
        wait_edges(1);
        check("pwr_e10_reset", 32'(reset_out), 32'h2);
        check("pwr_e10_ready", 32'(ready_out), 32'h0);
        wait_edges(3);
        check("pwr_e13_reset", 32'(reset_out), 32'h2);
        wait_edges(1);
        check("pwr_e14_reset", 32'(reset_out), 32'h0);
        check("pwr_e14_ready", 32'(ready_out), 32'h1);

        // Short button press (10 cycles) is filtered out.
        @(negedge clk_in);
        btn_in = 1'b1;
        repeat (10) @(negedge clk_in);
        btn_in = 1'b0;
        wait_edges(30);
        check("short_btn_reset", 32'(reset_out), 32'h0);
        check("short_btn_ready", 32'(ready_out), 32'h1);

        // Long button press (20 cycles): reset at edge 19 after the press.
        @(negedge clk_in);
        btn_in = 1'b1;
        wait_edges(18);
        check("btn_e18_reset", 32'(reset_out), 32'h0);
        wait_edges(1);
        check("btn_e19_reset", 32'(reset_out), 32'h3);
        check("btn_e19_ready", 32'(ready_out), 32'h0);
        check("btn_e19_cause", 32'(cause_out), 32'(c_CAUSE_BTN));
        @(negedge clk_in);
        @(negedge clk_in);
        btn_in = 1'b0;
        // Debounced button drops at edge 38; ch0 releases 8 quiet edges later.
        wait_edges(25);
        check("btn_e45_reset", 32'(reset_out), 32'h3);
        wait_edges(1);
        check("btn_e46_reset", 32'(reset_out), 32'h2);
        wait_edges(10);
        check("btn_e56_ready", 32'(ready_out), 32'h1);

        // One-cycle lock loss: reset at edge 3, then software request mid-release.
        @(negedge clk_in);
        locked_in = 1'b0;
        @(negedge clk_in);
        locked_in = 1'b1;
        wait_edges(1);
        check("lock_e2_reset", 32'(reset_out), 32'h0);
        wait_edges(1);
        check("lock_e3_reset", 32'(reset_out), 32'h3);
        check("lock_e3_cause", 32'(cause_out), 32'(c_CAUSE_LOCK));
        wait_edges(8);
        check("lock_e11_reset", 32'(reset_out), 32'h2);
        @(negedge clk_in);
        sw_req_in = 1'b1;
        wait_edges(1);
        check("sw_e12_reset", 32'(reset_out), 32'h3);
        check("sw_e12_cause", 32'(cause_out), 32'(c_CAUSE_SW));
        @(negedge clk_in);
        sw_req_in = 1'b0;
        wait_edges(7);
        check("sw_e19_reset", 32'(reset_out), 32'h3);
        wait_edges(1);
        check("sw_e20_reset", 32'(reset_out), 32'h2);
        wait_edges(10);
        check("sw_e30_ready", 32'(ready_out), 32'h1);

        // Lock loss and software request seen on the same edge: lock wins.
        @(negedge clk_in);
        locked_in = 1'b0;
        @(negedge clk_in);
        locked_in = 1'b1;
        @(negedge clk_in);
        sw_req_in = 1'b1;
        wait_edges(1);
        check("both_e3_reset", 32'(reset_out), 32'h3);
        check("both_e3_cause", 32'(cause_out), 32'(c_CAUSE_LOCK));
        @(negedge clk_in);
        sw_req_in = 1'b0;
        wait_edges(20);
        check("both_ready", 32'(ready_out), 32'h1);

        // Asynchronous reset pulse in the middle of RELEASE.
        @(negedge clk_in);
        sw_req_in = 1'b1;
        @(negedge clk_in);
        sw_req_in = 1'b0;
        wait_edges(8);
        check("arst_pre_reset", 32'(reset_out), 32'h2);
        #1;
        reset_in = 1'b1;
        #1;
        check("arst_now_reset", 32'(reset_out), 32'h3);
        check("arst_now_ready", 32'(ready_out), 32'h0);
        check("arst_now_cause", 32'(cause_out), 32'h0);
        @(negedge clk_in);
        reset_in = 1'b0;
        wait_edges(10);
        check("arst_e10_reset", 32'(reset_out), 32'h2);
        wait_edges(4);
        check("arst_e14_reset", 32'(reset_out), 32'h0);
        check("arst_e14_ready", 32'(ready_out), 32'h1);

        wait_edges(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, number of reset domains (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, button stability window (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 8, minimum all-asserted time after the last trigger (>=1).
REQ-005 SHALL have parameter STAGGER_CYCLES, default 4, gap between consecutive channel releases (>=1).
REQ-006 SHALL have port clk_in, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_in, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port btn_in, input, 1 bit: asynchronous reset button, active-high.
REQ-009 SHALL have port locked_in, input, 1 bit: asynchronous PLL lock, high = locked.
REQ-010 SHALL have port sw_req_in, input, 1 bit: synchronous software reset request, sampled each cycle.
REQ-011 SHALL have port reset_out, output, NUM_CHANNELS bits: per-domain reset, active-high, registered.
REQ-012 SHALL have port ready_out, output, 1 bit: high when every channel is released.
REQ-013 SHALL have port cause_out, output, 2 bits: cause of the last reset.

Function
REQ-014 SHALL pass btn_in and locked_in each through SYNC_STAGES flops; synchronizer reset value 0.
REQ-015 SHALL change the debounced button only after the synchronized button holds the new value for DEBOUNCE_CYCLES consecutive edges; any mismatch restarts the count.
REQ-016 SHALL define trigger = debounced button OR NOT synchronized lock OR sw_req_in.
REQ-017 SHALL implement states HOLD, RELEASE, RUN.
REQ-018 HOLD: all reset_out bits 1, ready_out 0; hold counter cleared on every trigger cycle, incremented otherwise.
REQ-019 HOLD->RELEASE on the edge where the counter reaches HOLD_CYCLES; reset_out[0] clears on that edge; with NUM_CHANNELS=1 go directly to RUN.
REQ-020 RELEASE: reset_out[k] clears exactly STAGGER_CYCLES edges after reset_out[k-1]; channels release strictly in ascending index.
REQ-021 RELEASE->RUN on the edge clearing reset_out[NUM_CHANNELS-1]; ready_out rises on that same edge.
REQ-022 RUN/RELEASE: trigger active -> HOLD on next edge; all reset_out bits 1 and ready_out 0 on that edge; counters cleared.
REQ-023 Held button or lost lock SHALL keep the block in HOLD indefinitely; release begins HOLD_CYCLES after trigger drops.
REQ-024 Button latency: press to reset_out assertion = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
REQ-025 Counters SHALL be sized $clog2(max+1) and SHALL never wrap.

Reset
REQ-026 reset_in high SHALL asynchronously force: reset_out all ones, ready_out 0, state HOLD, all counters 0, synchronizers and debounced button 0, cause_out 2'b00.
REQ-027 After reset_in falls with locked_in=1, btn_in=0: reset_out[0] clears SYNC_STAGES + HOLD_CYCLES edges later.

Configuration
REQ-028 Macro RESET_SEQ_CAUSE_EN SHALL compile in cause tracking: on entry to HOLD from RELEASE/RUN, cause_out latches 01 button, 10 lock loss, 11 software; simultaneous priority lock > button > software; 00 = reset_in only.
REQ-029 Without RESET_SEQ_CAUSE_EN, cause_out SHALL be constant 2'b00 with no cause register.

Verification (defaults)
REQ-030 Release reset_in, locked_in=1 -> reset_out[0] clears at edge 10, reset_out[1] at edge 14, ready_out rises at edge 14.
REQ-031 In RUN, btn_in high 10 cycles -> no reset; held 20 cycles -> reset_out=2'b11 at edge 19 after press, release restarts after btn drop + debounce + 8.
REQ-032 In RUN, locked_in low 1 cycle -> reset_out=2'b11 at edge 3, cause_out=10 (macro on), re-release sequence as REQ-030 timing.
REQ-033 In RELEASE after ch0 cleared, sw_req_in pulse -> both channels asserted next edge, cause_out=11, full HOLD_CYCLES restart.
REQ-034 Same cycle sw_req_in and lock loss -> cause_out=10; macro off -> cause_out stays 00.
REQ-035 reset_in pulse mid-RELEASE, asynchronous to clk_in -> reset_out=2'b11 and ready_out=0 immediately, before the next edge.
